// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to binary converter.
// One digit is folded into the accumulator per clock (acc*10 + digit),
// most significant digit first, so a request takes DIGITS busy cycles
// followed by a single-cycle done pulse.
// Optional feature macro: BCD_CHECK_EN -- flags operands containing a
// nibble above 9; such a conversion still runs full latency and then
// reports binary=0 with error held high until the next accepted start.
// Without the macro error is constant 0 and nibbles 10-15 are used raw.
module bcd_to_binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t              state_r;
    logic [4*DIGITS-1:0] shift_r;
    logic [BIN_W-1:0]    acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [3:0]          digit_s;
    logic [BIN_W-1:0]    acc_next_s;

`ifdef BCD_CHECK_EN
    logic                bad_r;

    // True when any nibble of the operand is not a valid decimal digit.
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] value);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction
`endif

    // Next accumulator value: acc*10 + current top digit, wrapped to BIN_W.
    always_comb begin
        digit_s    = shift_r[4*DIGITS-1 -: 4];
        acc_next_s = (acc_r << 2'd3) + (acc_r << 2'd1) + BIN_W'(digit_s);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= {(4*DIGITS){1'b0}};
            acc_r   <= {BIN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            binary  <= {BIN_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef BCD_CHECK_EN
            bad_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifndef BCD_CHECK_EN
            error <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r <= bcd;
                        acc_r   <= {BIN_W{1'b0}};
                        cnt_r   <= CNT_W'(DIGITS - 1);
                        busy    <= 1'b1;
                        state_r <= CONVERT;
`ifdef BCD_CHECK_EN
                        bad_r   <= has_bad_digit(bcd);
                        error   <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONVERT: begin
                    acc_r   <= acc_next_s;
                    shift_r <= shift_r << 3'd4;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
`ifdef BCD_CHECK_EN
                        binary  <= bad_r ? {BIN_W{1'b0}} : acc_next_s;
                        error   <= bad_r;
`else
                        binary  <= acc_next_s;
`endif
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary (DIGITS=4, BIN_W=14).
// A cycle model predicts busy/done timing; expected results are pushed
// to a scoreboard queue when a start is accepted and popped on done.
module tb_bcd_to_binary;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk;
    logic              reset;
    logic              start;
    logic [15:0]       bcd;
    logic [BIN_W-1:0]  binary;
    logic              busy;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [14:0] sb_q[$];
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [13:0] m_bin  = 14'd0;
    logic        m_err  = 1'b0;
    int          cyc    = 0;
    int          last_done_cyc = 0;
    int          prev_done_cyc = 0;

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference conversion: {error, binary}
    function automatic logic [14:0] ref_conv(input logic [15:0] v);
        int   acc;
        logic bad;
        logic [3:0] nib;
        acc = 0;
        bad = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            nib = v[4*i +: 4];
            if (nib > 4'd9) bad = 1'b1;
            acc = (acc * 10 + int'(nib)) % 16384;
        end
`ifdef BCD_CHECK_EN
        if (bad) return {1'b1, 14'd0};
`endif
        return {1'b0, acc[13:0]};
    endfunction

    // Cycle model / scoreboard producer and consumer
    always @(posedge clk) begin
        logic [14:0] e;
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_cnt = 0;
            sb_q.delete();
            m_bin = 14'd0;
            m_err = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                sb_q.push_back(ref_conv(bcd));
                m_err = 1'b0;
                m_cnt = DIGITS;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    m_bin = e[13:0];
                    m_err = e[14];
                end
            end
        end
    end

    // Per-cycle output comparison against the model
    always @(negedge clk) begin
        check("busy",   {31'd0, busy},  {31'd0, (m_cnt != 0)});
        check("done",   {31'd0, done},  {31'd0, m_done});
        check("binary", {18'd0, binary}, {18'd0, m_bin});
        check("error",  {31'd0, error}, {31'd0, m_err});
    end

    task automatic pulse_start(input logic [15:0] v);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1'b1;
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bcd   = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_binary", {18'd0, binary}, 32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_error",  {31'd0, error},  32'd0);
        reset = 1'b0;

        // reset wins over start in the same cycle
        @(negedge clk);
        reset = 1'b1; start = 1'b1; bcd = 16'h1111;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // 9999
        pulse_start(16'h9999);
        wait_done(10);
        check("bin_9999", {18'd0, binary}, 32'd9999);
        check("err_9999", {31'd0, error},  32'd0);

        pulse_start(16'h0000);
        wait_done(10);
        check("bin_0000", {18'd0, binary}, 32'd0);
        pulse_start(16'h0001);
        wait_done(10);
        check("bin_0001", {18'd0, binary}, 32'd1);
        repeat (2) @(negedge clk);

        // start held high, operand changes mid-conversion
        @(negedge clk);
        bcd = 16'h1234; start = 1'b1;
        repeat (2) @(negedge clk);
        bcd = 16'h5678;
        wait_done(10);
        check("bin_1234", {18'd0, binary}, 32'd1234);
        wait_done(10);
        start = 1'b0;
        check("bin_5678", {18'd0, binary}, 32'd5678);
        check("b2b_period", last_done_cyc - prev_done_cyc, 32'd5);
        repeat (3) @(negedge clk);

        // reset in the 2nd busy cycle aborts
        pulse_start(16'h8888);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_bin",  {18'd0, binary}, 32'd0);
        check("abort_busy", {31'd0, busy},   32'd0);
        pulse_start(16'h0042);
        wait_done(10);
        check("bin_0042", {18'd0, binary}, 32'd42);

        // invalid digit
        pulse_start(16'h12A4);
        wait_done(10);
`ifdef BCD_CHECK_EN
        check("bad_bin", {18'd0, binary}, 32'd0);
        check("bad_err", {31'd0, error},  32'd1);
        repeat (2) @(negedge clk);
        check("bad_err_hold", {31'd0, error}, 32'd1);
        pulse_start(16'h0007);
        check("bad_err_clr", {31'd0, error}, 32'd0);
        wait_done(10);
        check("bin_0007", {18'd0, binary}, 32'd7);
`else
        check("raw_bin", {18'd0, binary}, 32'd1304);
        check("raw_err", {31'd0, error},  32'd0);
`endif

        // a few random operands through the scoreboard
        for (int k = 0; k < 20; k++) begin
            pulse_start(16'($urandom));
            wait_done(10);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter DIGITS, default 4, number of packed BCD digits converted per request.
REQ-002 Parameter BIN_W, default 14, binary result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level-sampled conversion request; accepted only when not busy.
REQ-006 bcd  input  4*DIGITS  packed BCD operand; most significant digit in the top nibble.
REQ-007 binary  output  BIN_W  converted value; holds until the next completion.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when binary is updated.
REQ-010 error  output  1  invalid-digit flag; see Configuration.

Function
REQ-011 FSM states SHALL be IDLE and CONVERT only; DONE is not a separate state.
REQ-012 IDLE, start=1 at edge N: capture bcd into a digit shift register, clear the accumulator, load the digit counter with DIGITS-1, go to CONVERT, and set busy=1.
REQ-013 CONVERT, each edge: acc <= acc*10 + top nibble, formed as (acc<<3)+(acc<<1)+digit and truncated to BIN_W; shift the register left 4; decrement the counter.
REQ-014 Edge processing the last digit (edge N+DIGITS): binary <= final acc, done=1 for one cycle, busy=0, state goes to IDLE.
REQ-015 Latency: done is high in the cycle after edge N+DIGITS; busy is high for exactly DIGITS cycles.
REQ-016 start while busy=1 SHALL be ignored; the captured operand is unaffected by later bcd changes.
REQ-017 start=1 in the done cycle SHALL be accepted, giving back-to-back conversions every DIGITS+1 cycles.
REQ-018 A conversion with no accepted start SHALL never assert done or change binary.
REQ-019 Leading zero digits need no special handling; an all-zero operand yields binary=0 with normal latency.

Reset
REQ-020 reset=1 at an edge: state IDLE; binary=0, done=0, busy=0, error=0; accumulator, shift register and counter cleared.
REQ-021 reset SHALL take priority over start in the same cycle.
REQ-022 Reset mid-conversion SHALL abort the conversion with no done pulse; the next start after reset is handled normally.

Configuration
REQ-023 Macro BCD_CHECK_EN defined: at capture, any nibble > 9 is flagged.
REQ-024 In that case the conversion SHALL still run full latency, then on done set binary=0 and error=1.
REQ-025 With BCD_CHECK_EN defined, error SHALL hold until the next accepted start, where it clears.
REQ-026 Macro BCD_CHECK_EN undefined: error SHALL be tied 0, and nibbles 10-15 are used as raw values in REQ-013, with the result taken mod 2^BIN_W.

Verification
REQ-027 DIGITS=4, bcd=16'h9999, one-cycle start -> busy high 4 cycles, then done pulse with binary=9999 (14'h270F), error=0.
REQ-028 bcd=16'h0000 -> done after 4 busy cycles, binary=0; bcd=16'h0001 -> binary=1.
REQ-029 start held high, bcd=16'h1234 -> done every 5 cycles with binary=1234; bcd changed to 16'h5678 mid-conversion -> current result 1234, next result 5678.
REQ-030 reset asserted in the 2nd busy cycle of bcd=16'h8888 -> no done, binary=0; then bcd=16'h0042 start -> binary=42.
REQ-031 bcd=16'h12A4: with BCD_CHECK_EN -> done, error=1, binary=0, and error clears on the next start; without it -> binary=1304, error=0.
